// File: rtl/key_onehot_latch.sv
// Eight-key debouncer feeding a one-hot grant latch: presses queue as pending bits
// and are handed out lowest index first, each held on d/valid until acknowledged.
module key_onehot_latch #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] key_in,
    input  logic       ack,
    output logic [7:0] d,
    output logic       valid,
    output logic       overflow
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    logic [7:0]            sync1_q, sync2_q;
    logic [7:0]            deb_q, deb_d;
    logic [7:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]            rise;
    logic [7:0]            pending_q, pending_d;
    logic [7:0]            lowest;
    logic [7:0]            grant_mask;
    logic                  grant;
    state_t                state_q;
    logic [7:0]            d_q;
    logic                  valid_q;
    logic                  overflow_q;

    // The counter only reaches DEBOUNCE_CYCLES-1: the flip happens on the edge
    // that would have made it DEBOUNCE_CYCLES, so it can never wrap.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        deb_d = deb_q;
        cnt_d = '0;
        rise  = '0;
        for (int i = 0; i < 8; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync2_q[i];
                    rise[i]  = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        lowest     = pending_q & (~pending_q + 8'd1);
        grant      = (state_q == IDLE) && (pending_q != 8'h00);
        grant_mask = grant ? lowest : 8'h00;
        // A fresh rise on the bit being granted re-arms it instead of overflowing.
        pending_d  = (pending_q & ~grant_mask) | rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            // NOTE: the counter array is reset too; a stale count after reset would shorten the first debounce.
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sync1_q <= key_in;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            d_q        <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= |(rise & pending_q & ~grant_mask);
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        d_q     <= lowest;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end else begin
                        d_q     <= 8'h00;
                        valid_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (ack) begin
                        d_q     <= 8'h00;
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign d        = d_q;
    assign valid    = valid_q;
    assign overflow = overflow_q;

endmodule

// File: doc/key_onehot_latch.md
KEY_ONEHOT_LATCH -- requirements
Module: key_onehot_latch

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, range 2..255: consecutive stable cycles required before a debounced level changes.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 key_in  input  8  raw asynchronous key lines, active-high, bit i = key i.
REQ-005 ack  input  1  consumer acknowledge; sampled only in state HOLD.
REQ-006 d  output  8  registered one-hot key code for the downstream 8-to-3 encoder; 8'h00 when no grant.
REQ-007 valid  output  1  registered; high while d carries a granted key.
REQ-008 overflow  output  1  registered one-cycle pulse when a press is dropped.

Function
REQ-009 Each key_in bit SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-010 Per bit, a counter SHALL increment each cycle sync2 != debounced level and clear to 0 on any cycle they are equal.
REQ-011 The debounced level SHALL take the sync2 value on the edge completing DEBOUNCE_CYCLES consecutive differing cycles, and that bit's counter SHALL clear on the same edge.
REQ-012 Counter width SHALL be ceil(log2(DEBOUNCE_CYCLES+1)); counters SHALL never wrap.
REQ-013 A debounced 0->1 transition SHALL set pending[i] on the same edge; 1->0 transitions SHALL have no effect.
REQ-014 If pending[i] is already set when a new 0->1 transition occurs on bit i, the press SHALL be dropped and overflow SHALL pulse high for exactly one cycle.
REQ-015 FSM states: IDLE, HOLD; reset state IDLE.
REQ-016 IDLE, pending != 0: on the next edge load d with the lowest-index set pending bit (one-hot), clear that pending bit, set valid=1, go to HOLD.
REQ-017 IDLE, pending == 0: d=8'h00, valid=0, remain IDLE; ack ignored.
REQ-018 HOLD: d and valid SHALL be held constant until ack is sampled high; on that edge d=8'h00, valid=0, go to IDLE.
REQ-019 Minimum valid high time SHALL be 1 cycle; valid SHALL be low for at least 1 cycle between consecutive grants.
REQ-020 Latency: with key_in rising settled before edge 1, valid SHALL rise on edge 3+DEBOUNCE_CYCLES (edge 7 at default), provided FSM is IDLE and pending was empty.
REQ-021 Simultaneous: if the bit being granted/cleared in REQ-016 gets a new debounced rise on the same edge, pending[i] SHALL remain set and no overflow SHALL occur.
REQ-022 Simultaneous presses on several bits SHALL all set pending and be granted one per HOLD cycle in ascending index order.
REQ-023 d SHALL always be 8'h00 or exactly one bit set; it SHALL never be multi-hot.
REQ-024 Glitches shorter than DEBOUNCE_CYCLES cycles at sync2 SHALL produce no pending bit and no grant.

Reset
REQ-025 On rst_n low, asynchronously: d=8'h00, valid=0, overflow=0, state=IDLE, pending=0, all sync flops, debounced levels and counters = 0.
REQ-026 Reset asserted mid-HOLD SHALL abort the grant immediately; the lost grant SHALL not be reissued.
REQ-027 A key held high through reset release SHALL be detected as a new press after the normal latency of REQ-020.

Verification
REQ-028 key_in=8'h04 held from edge 1, DEBOUNCE_CYCLES=4 -> valid=1, d=8'h04 on edge 7; ack one cycle -> d=8'h00, valid=0 next edge.
REQ-029 key_in bit 3 pulsed high 3 cycles only -> no pending, valid stays 0, overflow stays 0.
REQ-030 key_in=8'h81 rising together -> grants d=8'h01 then, after ack plus one idle cycle, d=8'h80.
REQ-031 Bit 5 pressed, released, re-pressed while pending[5] set (FSM in HOLD for bit 0) -> overflow one-cycle pulse, bit 5 granted once.
REQ-032 rst_n low during HOLD with d=8'h10 -> d=8'h00, valid=0 without clock edge; after release, held key 4 re-granted at REQ-020 latency.
REQ-033 Random key_in stream with random ack delays -> d always 0 or one-hot, valid/d stable in HOLD until ack, grants in ascending index per batch.
